// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver FSM encoding, oversampling default,
// parity modes and the parity helper used by the receiver.
package usart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MAX_DATA_BITS  = 9;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Parity bit the transmitter should have sent for this word; unused
    // upper bits must be zero so they do not disturb the XOR.
    function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] word,
                                             input int mode);
        logic x;
        x = ^word;
        if (mode == PAR_ODD) begin
            expected_parity = ~x;
        end else begin
            expected_parity = x;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLOCK_50M,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two flops in series give a possibly metastable first sample a cycle to settle
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_oversampled.sv
// USART receiver: 16x oversampled start/data/parity/stop deserialiser with a
// level Valid/Ack handshake and one-cycle error pulses.
module uart_rx_oversampled
    import usart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 CLOCK_50M,
    input  logic                 RST,
    input  logic                 Enable,
    input  logic                 Tick,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] Data,
    output logic                 Valid,
    input  logic                 Ack,
    output logic                 FrameErr,
    output logic                 ParityErr,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t              state_r;
    rx_state_t              state_next_s;
    logic                   rx_s;
    logic                   tick_en_s;
    logic                   start_smp_s;
    logic                   data_smp_s;
    logic                   par_smp_s;
    logic                   stop_smp_s;
    logic                   word_ok_s;
    logic [TW-1:0]          tick_cnt_r;
    logic [BW-1:0]          bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_bad_r;
    logic [DATA_BITS-1:0]   data_r;
    logic                   valid_r;
    logic                   frame_err_r;
    logic                   parity_err_r;
    logic                   overrun_r;
    logic                   busy_r;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .CLOCK_50M (CLOCK_50M),
        .RST       (RST),
        .d         (RX),
        .q         (rx_s)
    );

    assign tick_en_s = Enable & Tick;

    // FSM state register
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM outputs: which sampling point (if any) falls on this cycle
    always_comb begin
        start_smp_s = 1'b0;
        data_smp_s  = 1'b0;
        par_smp_s   = 1'b0;
        stop_smp_s  = 1'b0;
        case (state_r)
            ST_START:  start_smp_s = tick_en_s & (tick_cnt_r == MID_CNT);
            ST_DATA:   data_smp_s  = tick_en_s & (tick_cnt_r == LAST_CNT);
            ST_PARITY: par_smp_s   = tick_en_s & (tick_cnt_r == LAST_CNT);
            ST_STOP:   stop_smp_s  = tick_en_s & (tick_cnt_r == LAST_CNT);
            default:   start_smp_s = 1'b0;
        endcase
        word_ok_s = stop_smp_s & rx_s & ~par_bad_r;
    end

    // FSM next state; Enable low forces IDLE and the frame is abandoned
    always_comb begin
        state_next_s = state_r;
        if (!Enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) state_next_s = ST_START;
                    else       state_next_s = ST_IDLE;
                end
                ST_START: begin
                    if (start_smp_s) state_next_s = rx_s ? ST_IDLE : ST_DATA;
                    else             state_next_s = ST_START;
                end
                ST_DATA: begin
                    if (data_smp_s && (bit_cnt_r == LAST_BIT))
                        state_next_s = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    else
                        state_next_s = ST_DATA;
                end
                ST_PARITY: begin
                    if (par_smp_s) state_next_s = ST_STOP;
                    else           state_next_s = ST_PARITY;
                end
                ST_STOP: begin
                    // Leave at stop mid-bit so a back-to-back start edge is seen
                    if (stop_smp_s) state_next_s = ST_IDLE;
                    else            state_next_s = ST_STOP;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Tick/bit counters, data shift register and parity verdict
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_bad_r  <= 1'b0;
        end else if (!Enable || (state_r == ST_IDLE)) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            par_bad_r  <= 1'b0;
        end else begin
            if (tick_en_s) begin
                if (start_smp_s || data_smp_s || par_smp_s) tick_cnt_r <= '0;
                else                                        tick_cnt_r <= tick_cnt_r + TW'(1);
            end
            if (data_smp_s) begin
                // LSB arrives first, so shift in from the top
                shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end
            if (par_smp_s) begin
                par_bad_r <= (rx_s != expected_parity(MAX_DATA_BITS'(shift_r), PARITY));
            end
        end
    end

    // Output word handshake and one-cycle error strobes at the stop sample
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            data_r       <= '0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r  <= stop_smp_s & ~rx_s;
            parity_err_r <= stop_smp_s & par_bad_r;
            overrun_r    <= word_ok_s & valid_r & ~Ack;
            // A simultaneous Ack frees the slot, so the new word is taken
            if (word_ok_s && (!valid_r || Ack)) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
            end else if (Ack && valid_r) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    // Busy mirrors the state the FSM is entering
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    assign Data      = data_r;
    assign Valid     = valid_r;
    assign FrameErr  = frame_err_r;
    assign ParityErr = parity_err_r;
    assign Overrun   = overrun_r;
    assign Busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: an 8N1 instance and an 8E1 instance
// share the serial line; only one is enabled at a time.
module tb_uart_rx_oversampled;

    localparam int EV_WORD    = 0;
    localparam int EV_FRAME   = 1;
    localparam int EV_PARITY  = 2;
    localparam int EV_OVERRUN = 3;

    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       en1, en2;
    logic       tick;
    logic       rx;
    logic       ack1, ack2;
    logic [7:0] d1, d2;
    logic       v1, v2, fe1, fe2, pe1, pe2, ov1, ov2, b1, b2;

    ev_t        exp_q[$];
    int         vectors;
    int         miscompares;
    int         cyc;
    int         last_tick_cyc;
    logic       prev_valid [2];
    logic [7:0] prev_data  [2];

    uart_rx_oversampled #(.DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16)) dut_8n1 (
        .CLOCK_50M (clk), .RST (rst), .Enable (en1), .Tick (tick), .RX (rx),
        .Data (d1), .Valid (v1), .Ack (ack1), .FrameErr (fe1),
        .ParityErr (pe1), .Overrun (ov1), .Busy (b1)
    );

    uart_rx_oversampled #(.DATA_BITS(8), .PARITY(2), .OVERSAMPLE(16)) dut_8e1 (
        .CLOCK_50M (clk), .RST (rst), .Enable (en2), .Tick (tick), .RX (rx),
        .Data (d2), .Valid (v2), .Ack (ack2), .FrameErr (fe2),
        .ParityErr (pe2), .Overrun (ov2), .Busy (b2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // 16x baud strobe: one clock high every 27 clocks
    initial begin
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (div == 26) begin
                div  = 0;
                tick = 1'b1;
            end else begin
                div  = div + 1;
                tick = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int dut, input int kind, input logic [7:0] data);
        ev_t e;
        e.dut  = dut;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int id, input int kind, input logic [7:0] data, input logic busy);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: dut%0d kind %0d data 0x%0h, expected none (t=%0t)",
                     id, kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_dut", id, e.dut);
            chk("event_kind", kind, e.kind);
            if (kind == EV_WORD && e.kind == EV_WORD) begin
                chk("word_data", int'(data), int'(e.data));
                chk("busy_at_valid", int'(busy), 0);
                chk("valid_latency", cyc - last_tick_cyc, 1);
            end
        end
    endtask

    task automatic scan(input int id, input logic valid, input logic [7:0] data,
                        input logic fe, input logic pe, input logic ov, input logic busy);
        if (valid && (!prev_valid[id] || data != prev_data[id])) observe(id, EV_WORD, data, busy);
        if (fe) observe(id, EV_FRAME, data, busy);
        if (pe) observe(id, EV_PARITY, data, busy);
        if (ov) observe(id, EV_OVERRUN, data, busy);
        prev_valid[id] = valid;
        prev_data[id]  = data;
    endtask

    // Monitor: any output event pops the next expectation and is compared
    always @(negedge clk) begin
        cyc = cyc + 1;
        scan(0, v1, d1, fe1, pe1, ov1, b1);
        scan(1, v2, d2, fe2, pe2, ov2, b2);
        if (tick) last_tick_cyc = cyc;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge clk);
                #2;
            end while (tick !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        wait_ticks(n);
    endtask

    // One frame; stop bit is held 16 ticks when high, 9 ticks when forced low
    task automatic send_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                              input logic stop_bit, input logic ack_on_stop);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(data[i], 16);
        if (with_par) send_bit(par_bit, 16);
        rx = stop_bit;
        wait_ticks(8);
        if (ack_on_stop) begin
            ack1 = 1'b1;
            @(posedge clk);
            #1;
            ack1 = 1'b0;
        end
        if (stop_bit) begin
            wait_ticks(8);
        end else begin
            wait_ticks(1);
            rx = 1'b1;
            wait_ticks(7);
        end
    endtask

    task automatic pulse_ack1();
        @(posedge clk);
        #1;
        ack1 = 1'b1;
        @(posedge clk);
        #1;
        ack1 = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        last_tick_cyc = -10;
        prev_valid[0] = 1'b0;
        prev_valid[1] = 1'b0;
        prev_data[0]  = 8'h00;
        prev_data[1]  = 8'h00;
        rst  = 1'b1;
        en1  = 1'b1;
        en2  = 1'b0;
        rx   = 1'b1;
        ack1 = 1'b0;
        ack2 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_data1", int'(d1), 0);
        chk("rst_valid1", int'(v1), 0);
        chk("rst_busy1", int'(b1), 0);
        chk("rst_flags1", int'({fe1, pe1, ov1}), 0);
        chk("rst_data2", int'(d2), 0);
        chk("rst_valid2", int'(v2), 0);
        chk("rst_busy2", int'(b2), 0);

        // 0x55, 8N1, no Ack
        expect_ev(0, EV_WORD, 8'h55);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("hold_valid_0x55", int'(v1), 1);
        pulse_ack1();
        chk("ack_clears_valid", int'(v1), 0);
        chk("data_kept_after_ack", int'(d1), 8'h55);

        // Start glitch of 5 ticks: rejected silently
        send_bit(1'b0, 5);
        send_bit(1'b1, 20);
        chk("glitch_busy", int'(b1), 0);
        chk("glitch_valid", int'(v1), 0);

        // 0xA3 with stop bit low: FrameErr only
        expect_ev(0, EV_FRAME, 8'h00);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ticks(20);
        chk("frameerr_no_valid", int'(v1), 0);
        chk("frameerr_data_kept", int'(d1), 8'h55);

        // 0x11 then 0x22 back-to-back, no Ack: second word overruns
        expect_ev(0, EV_WORD, 8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_ev(0, EV_OVERRUN, 8'h00);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("overrun_data_kept", int'(d1), 8'h11);
        chk("overrun_valid", int'(v1), 1);

        // Repeat with Ack on the 0x22 stop sample: accept wins
        expect_ev(0, EV_OVERRUN, 8'h00);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_ev(0, EV_WORD, 8'h22);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_ticks(4);
        chk("ack_wins_data", int'(d1), 8'h22);
        chk("ack_wins_valid", int'(v1), 1);

        // Even parity instance: 0x07 needs parity 1
        en1 = 1'b0;
        en2 = 1'b1;
        wait_ticks(2);
        expect_ev(1, EV_PARITY, 8'h00);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("parity_bad_no_valid", int'(v2), 0);
        expect_ev(1, EV_WORD, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_ticks(4);
        chk("parity_ok_valid", int'(v2), 1);
        en2 = 1'b0;
        en1 = 1'b1;
        wait_ticks(2);

        // Reset in the middle of data bit 4 of 0x3C, then a clean 0x3C
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        chk("busy_mid_frame", int'(b1), 1);
        rst = 1'b1;
        #1;
        chk("midrst_data1", int'(d1), 0);
        chk("midrst_valid1", int'(v1), 0);
        chk("midrst_busy1", int'(b1), 0);
        chk("midrst_valid2", int'(v2), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(20);
        expect_ev(0, EV_WORD, 8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("after_rst_valid", int'(v1), 1);

        chk("pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
